// File: rtl/nabp_domino_feeder.sv
// Domino feeder: takes image RAM read data for each addressed sample and ripples
// it down a systolic chain of PE partitions, one cycle of skew per PE. Produces
// per-PE valid/kick strobes, an end-of-line pulse and a sticky protocol error.

// One link of the domino chain. Stage 0 loads only on valid read data and holds
// its sample otherwise; later stages load every cycle from their predecessor.
module nabp_domino_stage #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  load,
  input  logic                  in_valid,
  input  logic                  in_first,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  output logic                  out_first,
  output logic [DATA_WIDTH-1:0] out_data
);

  // Capture sample, valid and first-of-line flag; bubbles clear valid/first.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      out_first <= 1'b0;
      out_data  <= '0;
    end else if (load) begin
      out_valid <= in_valid;
      out_first <= in_first;
      out_data  <= in_data;
    end else begin
      out_valid <= 1'b0;
      out_first <= 1'b0;
    end
  end

endmodule

module nabp_domino_feeder #(
  parameter int DATA_WIDTH       = 8,
  parameter int NO_OF_PARTITIONS = 4,
  parameter int LINE_LENGTH      = 256,
  parameter int RAM_LATENCY      = 1
) (
  input  logic                                   clk,
  input  logic                                   reset_n,
  input  logic                                   ir_kick,
  input  logic                                   ir_enable,
  input  logic [DATA_WIDTH-1:0]                  ir_data,
  output logic [NO_OF_PARTITIONS*DATA_WIDTH-1:0] pe_data,
  output logic [NO_OF_PARTITIONS-1:0]            pe_valid,
  output logic [NO_OF_PARTITIONS-1:0]            pe_kick,
  output logic                                   line_done,
  output logic                                   busy,
  output logic                                   err
);

  localparam int CNT_W = $clog2(LINE_LENGTH + 1);
  localparam logic [CNT_W-1:0] LEN_C  = CNT_W'(LINE_LENGTH);
  localparam logic [CNT_W-1:0] LAST_C = CNT_W'(LINE_LENGTH - 1);

  // One-hot so that corrupted encodings are detectable.
  typedef enum logic [3:0] {
    IDLE   = 4'b0001,
    FILL   = 4'b0010,
    STREAM = 4'b0100,
    DRAIN  = 4'b1000
  } state_t;

  state_t state, state_nxt;

  logic [CNT_W-1:0] in_cnt, out_cnt;
  logic             accept, kick_ok, bad_state, err_set;
  logic             rd_valid, rd_first;

  logic [RAM_LATENCY-1:0] rd_pipe, first_pipe;

  logic [NO_OF_PARTITIONS-1:0][DATA_WIDTH-1:0] stg_data;
  logic [NO_OF_PARTITIONS-1:0]                 stg_valid, stg_first;

  // An enable is only taken while a line is open and not yet full.
  assign accept  = ir_enable && ((state == FILL) || (state == STREAM)) && (in_cnt < LEN_C);
  assign kick_ok = ir_kick && (state == IDLE);
  assign err_set = (ir_kick && (state != IDLE)) || (ir_enable && !accept) || bad_state;

  assign rd_valid = rd_pipe[RAM_LATENCY-1];
  assign rd_first = first_pipe[RAM_LATENCY-1];

  // Delay accepted enables (and their first-of-line tag) to line up with ir_data.
  generate
    if (RAM_LATENCY == 1) begin : g_lat1
      always_ff @(posedge clk) begin
        if (!reset_n) begin
          rd_pipe    <= '0;
          first_pipe <= '0;
        end else begin
          rd_pipe    <= accept;
          first_pipe <= accept && (in_cnt == '0);
        end
      end
    end else begin : g_latn
      always_ff @(posedge clk) begin
        if (!reset_n) begin
          rd_pipe    <= '0;
          first_pipe <= '0;
        end else begin
          rd_pipe    <= {rd_pipe[RAM_LATENCY-2:0], accept};
          first_pipe <= {first_pipe[RAM_LATENCY-2:0], accept && (in_cnt == '0)};
        end
      end
    end
  endgenerate

  // Domino chain: PE k sees each sample k cycles after PE 0.
  generate
    for (genvar k = 0; k < NO_OF_PARTITIONS; k++) begin : g_pe
      if (k == 0) begin : g_head
        nabp_domino_stage #(.DATA_WIDTH(DATA_WIDTH)) u_stage (
          .clk       (clk),
          .reset_n   (reset_n),
          .load      (rd_valid),
          .in_valid  (rd_valid),
          .in_first  (rd_first),
          .in_data   (ir_data),
          .out_valid (stg_valid[k]),
          .out_first (stg_first[k]),
          .out_data  (stg_data[k])
        );
      end else begin : g_link
        nabp_domino_stage #(.DATA_WIDTH(DATA_WIDTH)) u_stage (
          .clk       (clk),
          .reset_n   (reset_n),
          .load      (1'b1),
          .in_valid  (stg_valid[k-1]),
          .in_first  (stg_first[k-1]),
          .in_data   (stg_data[k-1]),
          .out_valid (stg_valid[k]),
          .out_first (stg_first[k]),
          .out_data  (stg_data[k])
        );
      end
    end
  endgenerate

  assign pe_data  = stg_data;
  assign pe_valid = stg_valid;
  assign pe_kick  = stg_first;
  assign busy     = (state != IDLE);

  // State register.
  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Line sequencing; the final accepted enable goes straight to DRAIN.
  always_comb begin
    state_nxt = state;
    bad_state = 1'b0;
    case (state)
      IDLE:    if (ir_kick) state_nxt = FILL;
      FILL:    if (accept)  state_nxt = (in_cnt == LAST_C) ? DRAIN : STREAM;
      STREAM:  if (accept && (in_cnt == LAST_C)) state_nxt = DRAIN;
      DRAIN:   if (out_cnt == LEN_C) state_nxt = IDLE;
      default: begin
        state_nxt = IDLE;
        bad_state = 1'b1;
      end
    endcase
  end

  // Saturating input/output sample counters, cleared by an accepted kick.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      in_cnt  <= '0;
      out_cnt <= '0;
    end else if (kick_ok) begin
      in_cnt  <= '0;
      out_cnt <= '0;
    end else begin
      if (accept) in_cnt <= in_cnt + CNT_W'(1);
      if (stg_valid[NO_OF_PARTITIONS-1] && (out_cnt != LEN_C)) out_cnt <= out_cnt + CNT_W'(1);
    end
  end

  // End-of-line pulse follows the last PE's last sample; error is sticky.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      line_done <= 1'b0;
      err       <= 1'b0;
    end else begin
      line_done <= stg_valid[NO_OF_PARTITIONS-1] && (out_cnt == LAST_C) && (state == DRAIN);
      if (err_set) err <= 1'b1;
    end
  end

endmodule
